// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the inference controller: FSM encodings and limits.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam int MAX_DIGIT       = 9;
    localparam int DEF_TIMEOUT_CYC = 2_000_000;

endpackage

// File: rtl/rise_detect.sv
// One-register rising-edge detector with synchronous clear.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic d,
    output logic rise
);

    logic prev_q, prev_d;

    always_comb prev_d = clr ? 1'b0 : d;

    always_ff @(posedge clk) begin
        if (!resetn) prev_q <= 1'b0;
        else         prev_q <= prev_d;
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/inference_controller.sv
// Sequences one inference: image-port arbitration, draw freeze, clear/start strobes,
// result latch. Optional RUN watchdog built when INFER_TIMEOUT_EN is defined.
module inference_controller
    import nn_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int RESULT_W    = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_req,
    input  logic [ADDR_W-1:0]   disp_addr,
    input  logic [ADDR_W-1:0]   nn_addr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                nn_clr,
    output logic                nn_start,
    input  logic                nn_done,
    input  logic [RESULT_W-1:0] nn_result,
    output logic                owner_nn,
    output logic                draw_inhibit,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid,
    output logic                busy,
    output logic                error,
    output logic [2:0]          state_dbg
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                inhibit_q, inhibit_d;
    logic                clr_q, clr_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic                rvalid_q, rvalid_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                start_rise, done_rise, timeout_hit;

    rise_detect u_start_rd (
        .clk(clk), .resetn(resetn), .clr(1'b0), .d(start_req), .rise(start_rise)
    );

    // Cleared in ARM so a done level held over from the last run cannot complete this one.
    rise_detect u_done_rd (
        .clk(clk), .resetn(resetn), .clr(state_q == ST_ARM), .d(nn_done), .rise(done_rise)
    );

`ifdef INFER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    always_comb to_cnt_d = (state_q == ST_RUN && state_d == ST_RUN) ? to_cnt_q + 1'b1 : '0;
    assign timeout_hit = (state_q == ST_RUN) && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!resetn) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_rise) state_d = ST_ARM;
            ST_ARM:   state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (done_rise)        state_d = ST_DONE;
                else if (timeout_hit) state_d = ST_ERR;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Port ownership and strobes follow the next state so they line up with it.
    always_comb begin
        owner_d   = state_d inside {ST_ARM, ST_START, ST_RUN, ST_DONE};
        inhibit_d = owner_d;
        clr_d     = (state_d == ST_ARM);
        start_d   = (state_d == ST_START);
        busy_d    = (state_d != ST_IDLE);
        result_d  = result_q;
        rvalid_d  = rvalid_q;
        error_d   = error_q;
        case (state_q)
            ST_ARM: begin
                rvalid_d = 1'b0;
                error_d  = 1'b0;
            end
            ST_DONE: begin
                if (nn_result <= RESULT_W'(MAX_DIGIT)) begin
                    result_d = nn_result;
                    rvalid_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            ST_ERR:  error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            inhibit_q <= 1'b0;
            clr_q     <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            inhibit_q <= inhibit_d;
            clr_q     <= clr_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            rvalid_q  <= rvalid_d;
            result_q  <= result_d;
        end
    end

    assign mem_addr     = owner_q ? nn_addr : disp_addr;
    assign owner_nn     = owner_q;
    assign draw_inhibit = inhibit_q;
    assign nn_clr       = clr_q;
    assign nn_start     = start_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign result_valid = rvalid_q;
    assign result       = result_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_inference_controller.sv
// Directed bench for inference_controller; timeout cases built when INFER_TIMEOUT_EN is defined.
module tb_inference_controller;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_req;
    logic [15:0] disp_addr, nn_addr, mem_addr;
    logic        nn_clr, nn_start, nn_done;
    logic [3:0]  nn_result, result;
    logic        owner_nn, draw_inhibit, result_valid, busy, error;
    logic [2:0]  state_dbg;

    int n_vec = 0;
    int n_err = 0;

    inference_controller #(.ADDR_W(16), .RESULT_W(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .resetn(resetn), .start_req(start_req),
        .disp_addr(disp_addr), .nn_addr(nn_addr), .mem_addr(mem_addr),
        .nn_clr(nn_clr), .nn_start(nn_start), .nn_done(nn_done), .nn_result(nn_result),
        .owner_nn(owner_nn), .draw_inhibit(draw_inhibit), .result(result),
        .result_valid(result_valid), .busy(busy), .error(error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"},  state_dbg,    3'd0);
        chk({tag, ".owner"},  owner_nn,     1'b0);
        chk({tag, ".inhib"},  draw_inhibit, 1'b0);
        chk({tag, ".clr"},    nn_clr,       1'b0);
        chk({tag, ".start"},  nn_start,     1'b0);
        chk({tag, ".busy"},   busy,         1'b0);
        chk({tag, ".error"},  error,        1'b0);
        chk({tag, ".rvalid"}, result_valid, 1'b0);
        chk({tag, ".result"}, result,       4'd0);
        chk({tag, ".addr"},   mem_addr,     16'h0123);
    endtask

    // From IDLE with start_req low: raise it and walk to the first RUN cycle.
    task automatic launch();
        start_req = 1'b1;
        tick();
        tick();
        tick();
        start_req = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start_req = 1'b0; nn_done = 1'b0; nn_result = 4'd0;
        disp_addr = 16'h0123; nn_addr = 16'h0456;
        tick(3);
        chk_reset_vals("rst");
        resetn = 1'b1;
        tick();
        chk("idle.state", state_dbg, 3'd0);
        chk("idle.addr",  mem_addr,  16'h0123);

        // Basic run with strobe timing
        start_req = 1'b1;
        tick();
        chk("arm.state", state_dbg,    3'd1);
        chk("arm.clr",   nn_clr,       1'b1);
        chk("arm.start", nn_start,     1'b0);
        chk("arm.owner", owner_nn,     1'b1);
        chk("arm.inhib", draw_inhibit, 1'b1);
        chk("arm.busy",  busy,         1'b1);
        chk("arm.addr",  mem_addr,     16'h0456);
        tick();
        chk("st.state", state_dbg, 3'd2);
        chk("st.clr",   nn_clr,    1'b0);
        chk("st.start", nn_start,  1'b1);
        chk("st.owner", owner_nn,  1'b1);
        tick();
        chk("run.state", state_dbg, 3'd3);
        chk("run.start", nn_start,  1'b0);
        chk("run.addr",  mem_addr,  16'h0456);
        tick(2);
        chk("run.wait", state_dbg, 3'd3);
        nn_result = 4'd7; nn_done = 1'b1;
        tick();
        chk("done.state",  state_dbg,    3'd4);
        chk("done.addr",   mem_addr,     16'h0456);
        chk("done.rvalid", result_valid, 1'b0);
        tick();
        chk("post.state",  state_dbg,    3'd0);
        chk("post.result", result,       4'd7);
        chk("post.rvalid", result_valid, 1'b1);
        chk("post.owner",  owner_nn,     1'b0);
        chk("post.inhib",  draw_inhibit, 1'b0);
        chk("post.busy",   busy,         1'b0);
        chk("post.addr",   mem_addr,     16'h0123);

        // Stale done: nn_done still high from the previous run
        start_req = 1'b0;
        tick();
        launch();
        chk("stale.run",    state_dbg,    3'd3);
        chk("stale.rvclr",  result_valid, 1'b0);
        nn_result = 4'd3;
        tick(5);
        chk("stale.hold",   state_dbg, 3'd3);
        nn_done = 1'b0;
        tick();
        chk("stale.low",    state_dbg, 3'd3);
        nn_done = 1'b1;
        tick();
        chk("stale.done",   state_dbg, 3'd4);
        tick();
        chk("stale.result", result,       4'd3);
        chk("stale.rvalid", result_valid, 1'b1);

        // Out-of-range result
        launch();
        nn_done = 1'b0;
        tick();
        nn_result = 4'd12; nn_done = 1'b1;
        tick();
        chk("bad.done",   state_dbg, 3'd4);
        tick();
        chk("bad.state",  state_dbg,    3'd0);
        chk("bad.error",  error,        1'b1);
        chk("bad.rvalid", result_valid, 1'b0);

        // Error clears on the next run; start toggle in RUN ignored; reset mid-run
        launch();
        chk("clr.error", error, 1'b0);
        start_req = 1'b1;
        tick();
        chk("tog.ignore", state_dbg, 3'd3);
        start_req = 1'b0;
        tick();
        start_req = 1'b1;
        tick();
        chk("tog.ignore2", state_dbg, 3'd3);
        resetn = 1'b0; start_req = 1'b0; nn_done = 1'b0;
        tick();
        chk_reset_vals("midrst");
        resetn = 1'b1;
        tick(2);
        chk("midrst.idle", state_dbg, 3'd0);

`ifdef INFER_TIMEOUT_EN
        // Watchdog expiry after 16 RUN cycles
        launch();
        chk("to.run", state_dbg, 3'd3);
        tick(15);
        chk("to.c16", state_dbg, 3'd3);
        tick();
        chk("to.err", state_dbg, 3'd5);
        tick();
        chk("to.state", state_dbg,    3'd0);
        chk("to.error", error,        1'b1);
        chk("to.inhib", draw_inhibit, 1'b0);
        chk("to.owner", owner_nn,     1'b0);

        // Done edge on the 16th RUN cycle beats the watchdog
        launch();
        tick(15);
        nn_result = 4'd5; nn_done = 1'b1;
        tick();
        chk("race.done", state_dbg, 3'd4);
        tick();
        chk("race.result", result, 4'd5);
        chk("race.error",  error,  1'b0);
        nn_done = 1'b0;
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
